// File: rtl/sseg_pkg.sv
// Shared constants and types for the scanned seven-segment display.
// Segment patterns are {a,b,c,d,e,f,g}, active low.
package sseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b000_0001;
  localparam logic [6:0] SEG_1     = 7'b100_1111;
  localparam logic [6:0] SEG_2     = 7'b001_0010;
  localparam logic [6:0] SEG_3     = 7'b000_0110;
  localparam logic [6:0] SEG_4     = 7'b100_1100;
  localparam logic [6:0] SEG_5     = 7'b010_0100;
  localparam logic [6:0] SEG_6     = 7'b010_0000;
  localparam logic [6:0] SEG_7     = 7'b000_1111;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b000_1100;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_DASH  = 7'b111_1110;

  typedef enum logic {IDLE, SHIFT} conv_state_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, VALUE_W cycles.
// bcd carries the final result combinationally while done is high.
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int VALUE_W    = 8,
  parameter int BCD_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [VALUE_W-1:0]        value,
  input  logic                      load,
  output logic [BCD_DIGITS*4-1:0]   bcd,
  output logic                      done,
  output logic                      busy
);

  localparam int CW = $clog2(VALUE_W + 1);

  conv_state_e                           state;
  logic [VALUE_W-1:0]                    bin;
  logic [BCD_DIGITS-1:0][3:0]            acc, adj;
  logic [CW-1:0]                         cnt;
  logic [BCD_DIGITS*4+VALUE_W-1:0]       shifted;

  always_comb begin
    adj = acc;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (acc[i] >= 4'd5) adj[i] = acc[i] + 4'd3;
    shifted = {adj, bin} << 1;
  end

  // done marks the final shift so the display can capture on the same edge busy drops
  assign bcd  = shifted[BCD_DIGITS*4+VALUE_W-1:VALUE_W];
  assign done = (state == SHIFT) && (cnt == CW'(VALUE_W - 1));
  assign busy = (state == SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bin   <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          bin   <= value;
          acc   <= '0;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          {acc, bin} <= shifted;
          cnt        <= cnt + 1'b1;
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sseg_scan_display.sv
// N-digit common-anode display: binary load -> BCD -> time-multiplexed
// anodes with leading-zero blanking and overflow dashes.
module sseg_scan_display
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int VALUE_W       = 8,
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [VALUE_W-1:0]     value,
  input  logic                   load,
  output logic                   busy,
  output logic                   overflow,
  output logic [NUM_DIGITS-1:0]  an,
  output logic [6:0]             seg
);

  localparam int BCD_DIGITS = (NUM_DIGITS > (VALUE_W + 2) / 3) ? NUM_DIGITS : (VALUE_W + 2) / 3;
  localparam int RW         = $clog2(REFRESH_DIV);
  localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [BCD_DIGITS-1:0][3:0] bcd;
  logic                       done;
  logic [NUM_DIGITS-1:0][3:0] disp;
  logic [NUM_DIGITS-1:0]      blank;
  logic                       hi_nz, lead, wrap;
  logic [RW-1:0]              rcnt;
  logic [IW-1:0]              idx, idx_nxt;
  logic [6:0]                 seg_nxt;

  bin2bcd_seq #(.VALUE_W(VALUE_W), .BCD_DIGITS(BCD_DIGITS)) u_conv (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .bcd(bcd), .done(done), .busy(busy)
  );

  always_comb begin
    hi_nz = 1'b0;
    for (int i = NUM_DIGITS; i < BCD_DIGITS; i++)
      hi_nz = hi_nz | (bcd[i] != 4'd0);
  end

  // Walk down from the top digit; blanking stops at the first nonzero digit
  always_comb begin
    lead  = BLANK_LEADING;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead     = lead && (disp[i] == 4'd0);
      blank[i] = lead;
    end
  end

  // an/seg are registered from the next index so they always stay paired with idx
  always_comb begin
    wrap    = (rcnt == RW'(REFRESH_DIV - 1));
    idx_nxt = idx;
    if (wrap) idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    if (overflow)            seg_nxt = SEG_DASH;
    else if (blank[idx_nxt]) seg_nxt = SEG_BLANK;
    else                     seg_nxt = bcd_to_seg(disp[idx_nxt]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp     <= '0;
      overflow <= 1'b0;
      rcnt     <= '0;
      idx      <= '0;
      an       <= ~NUM_DIGITS'(1);
      seg      <= SEG_0;
    end else begin
      rcnt <= wrap ? '0 : rcnt + 1'b1;
      idx  <= idx_nxt;
      an   <= ~(NUM_DIGITS'(1) << idx_nxt);
      seg  <= seg_nxt;
      if (done) begin
        disp     <= bcd[NUM_DIGITS-1:0];
        overflow <= hi_nz;
      end
    end
  end

endmodule
